// File: rtl/score_display_pkg.sv
// score_display_pkg: shared states, widths and 7-segment codes for the score display.
package score_display_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
    localparam int SCORE_W = 14;
    localparam logic [SCORE_W-1:0] MAX_BCD = 14'd9999;
    localparam logic [6:0] SEG_CODES [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        return (n > 4'd9) ? SEG_DASH : SEG_CODES[n];
    endfunction
endpackage

// File: rtl/score_display_bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-add-3 converter, one input bit per clock.
module bin_to_bcd_seq
    import score_display_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [SCORE_W-1:0] value_i,
    output logic [15:0]        bcd_o,
    output logic               done_o,
    output logic               busy_o
);
    state_e      state_q, state_d;
    logic [29:0] sr_q, sr_d, adj;
    logic [3:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        adj = sr_q;
        for (int i = 0; i < 4; i++)
            adj[14+4*i +: 4] = (sr_q[14+4*i +: 4] >= 4'd5) ? sr_q[14+4*i +: 4] + 4'd3 : sr_q[14+4*i +: 4];
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start_i) begin
                sr_d    = {16'b0, value_i};
                cnt_d   = 4'd13;
                state_d = SHIFT;
            end
            SHIFT: begin
                sr_d    = {adj[28:0], 1'b0};
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd0) ? DONE : SHIFT;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bcd_o  = sr_q[29:14];
    assign done_o = (state_q == DONE);
    assign busy_o = (state_q != IDLE);
endmodule

// File: rtl/score_display.sv
// score_display: converts the binary score to BCD and multiplexes it onto a 4-digit 7-segment display.
module score_display
    import score_display_pkg::*;
#(
    parameter int REFRESH_BITS  = 18,
    parameter bit BLANK_LEADING = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    output logic [6:0]         seg,
    output logic               dp,
    output logic [3:0]         an,
    output logic               busy
);
    logic [REFRESH_BITS-1:0] cnt_q;
    logic [SCORE_W-1:0]      last_q, sat;
    logic [15:0]             dig_q, bcd;
    logic [6:0]              seg_q, seg_d;
    logic [3:0]              an_q, an_d;
    logic [1:0]              sel;
    logic                    start, done, blank;

    assign start = (score != last_q) && !busy;
    assign sat   = (score > MAX_BCD) ? MAX_BCD : score;

    bin_to_bcd_seq u_conv (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .value_i (sat),
        .bcd_o   (bcd),
        .done_o  (done),
        .busy_o  (busy)
    );

    // A digit is blanked when it and every digit above it is zero.
    always_comb begin
        sel   = cnt_q[REFRESH_BITS-1 -: 2];
        blank = BLANK_LEADING && (sel != 2'd0) && ((dig_q >> {sel, 2'b00}) == 16'd0);
        seg_d = blank ? SEG_BLANK : seg_of(dig_q[{sel, 2'b00} +: 4]);
        an_d  = blank ? 4'b1111 : ~(4'b0001 << sel);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            last_q <= '0;
            dig_q  <= '0;
            seg_q  <= 7'b1000000;
            an_q   <= 4'b1110;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            last_q <= start ? score : last_q;
            dig_q  <= done ? bcd : dig_q;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = 1'b1;
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: randomized and directed checks of score_display against a value-level model.
module tb_score_display;
    localparam int RB = 4;
    localparam int PW [0:3] = '{1, 10, 100, 1000};

    logic        clk = 0;
    logic        reset;
    logic [13:0] score;
    logic [6:0]  seg1, seg0;
    logic [3:0]  an1, an0;
    logic        dp1, dp0, busy1, busy0;

    logic [6:0] segtab [0:9];
    int checks = 0, errors = 0;
    int m_cnt, m_last, m_pend, m_timer, m_disp;
    logic [10:0] e1, e0;
    logic e_busy;

    score_display #(.REFRESH_BITS(RB), .BLANK_LEADING(1)) dut1 (
        .clk(clk), .reset(reset), .score(score), .seg(seg1), .dp(dp1), .an(an1), .busy(busy1));
    score_display #(.REFRESH_BITS(RB), .BLANK_LEADING(0)) dut0 (
        .clk(clk), .reset(reset), .score(score), .seg(seg0), .dp(dp0), .an(an0), .busy(busy0));

    always #5 clk = ~clk;

    function automatic logic [10:0] exp_out(int c, int v, bit bl);
        int k;
        k = (c >> (RB - 2)) & 3;
        if (bl && k > 0 && v < PW[k]) return {4'b1111, 7'b1111111};
        return {~(4'b0001 << k), segtab[(v / PW[k]) % 10]};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_last = 0; m_pend = 0; m_timer = 0; m_disp = 0;
        e1 = {4'b1110, 7'b1000000};
        e0 = e1;
    endtask

    // The display shows the saturated value 15 edges after capture; outputs lag the counter by one edge.
    task automatic model_step();
        e1 = exp_out(m_cnt, m_disp, 1);
        e0 = exp_out(m_cnt, m_disp, 0);
        m_cnt = (m_cnt + 1) % (1 << RB);
        if (m_timer == 0) begin
            if (int'(score) != m_last) begin
                m_pend  = (score > 9999) ? 9999 : int'(score);
                m_last  = int'(score);
                m_timer = 15;
            end
        end else begin
            m_timer--;
            if (m_timer == 0) m_disp = m_pend;
        end
    endtask

    task automatic chk(string tag, logic [10:0] got, logic [10:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (t=%0t score=%0d)", tag, got, exp, $time, score);
        end
    endtask

    task automatic check_all();
        e_busy = (m_timer != 0);
        chk("bl1_an_seg", {an1, seg1}, e1);
        chk("bl0_an_seg", {an0, seg0}, e0);
        chk("busy", {9'b0, busy1, busy0}, {9'b0, e_busy, e_busy});
        chk("dp", {9'b0, dp1, dp0}, 11'b11);
    endtask

    task automatic tick(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (reset) model_reset(); else model_step();
            #1;
            check_all();
        end
    endtask

    task automatic async_reset();
        #2;
        reset = 1;
        model_reset();
        #1;
        check_all();
    endtask

    initial begin
        segtab[0] = 7'b1000000; segtab[1] = 7'b1111001; segtab[2] = 7'b0100100;
        segtab[3] = 7'b0110000; segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
        segtab[6] = 7'b0000010; segtab[7] = 7'b1111000; segtab[8] = 7'b0000000;
        segtab[9] = 7'b0010000;
        model_reset();
        reset = 1;
        score = 0;
        tick(2);
        reset = 0;
        tick(40);
        score = 1234;  tick(40);
        score = 16383; tick(40);
        score = 7;     tick(40);
        score = 100;   tick(5);
        score = 205;   tick(60);
        score = 12000; tick(30);
        score = 13000; tick(30);
        score = 9999;  tick(30);
        score = 10000; tick(30);
        score = 4321;  tick(8);
        async_reset();
        tick(2);
        reset = 0;
        tick(40);
        for (int r = 0; r < 40; r++) begin
            score = ($urandom_range(0, 3) == 0) ? score : 14'($urandom_range(0, 16383));
            tick($urandom_range(1, 40));
        end
        tick(40);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Consumer end of the 14-bit score bus: takes the binary score and drives the board's 4-digit multiplexed 7-segment display.
- Converts binary to BCD sequentially (shift-add-3, one bit per clock).
- Latches the four digits and time-multiplexes them onto active-low segment/anode lines.
- Sits at top level between the score counter and the display pins.

Parameters:
- REFRESH_BITS, 18, width of the free-running refresh counter; its top 2 bits select the digit (100 MHz / 2^16 ≈ 1.5 kHz per digit). The bench uses 4.
- BLANK_LEADING, 1, 1 = leading zeros blanked (digit 0 always lit); 0 = all four digits always lit.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- score  in  14  binary score, 0..16383, may change on any cycle
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low, constant 1 (off)
- an  out  4  anodes, active-low, an[0] = rightmost (units) digit
- busy  out  1  high while a conversion is in progress

Behaviour:
- Reset values: all internal digits = 0; last_score = 0; state IDLE; refresh counter = 0; busy = 0; dp = 1; an = 4'b1110; seg = 7'b1000000 (shows "0").
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on a clock edge where score != last_score:
  - capture sat = (score > 9999) ? 9999 : score;
  - last_score <= score (raw value);
  - load the 30-bit shift register {16'b0, sat};
  - bit counter = 13; go to SHIFT; busy = 1.
- SHIFT, each cycle:
  - add 3 to every BCD nibble >= 5;
  - then shift the whole register left by 1;
  - decrement the counter; after the 14th shift, go to DONE.
- DONE: copy BCD nibbles [29:14] to the display digit registers; busy = 0; go to IDLE.
- Latency: the capture edge is N; the display digits change at edge N+15 (14 SHIFT edges plus 1 DONE edge). busy is high from N+1 through N+15. The next capture can happen no earlier than N+16.
- score changes while busy are ignored until IDLE. Because IDLE compares against last_score, the final stable value is always displayed, and intermediate values may be skipped.
- score unchanged: no conversion, no busy pulse.
- Saturation: any score 10000..16383 displays 9999. last_score holds the raw value, so 12000 -> 13000 does not retrigger visibly but does run a conversion.
- Refresh: the counter increments every clock and wraps. sel = counter[REFRESH_BITS-1 -: 2] drives digit index sel onto seg and an[sel] = 0. Exactly one anode is low per cycle unless that digit is blanked.
- Blanking (BLANK_LEADING=1): digit k (k>0) is blanked when it and all higher digits are 0. A blanked digit drives an = 4'b1111 and seg = 7'b1111111.
- Segment codes for 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Nibbles 10..15 are unreachable; decode them to 0111111 ("-").
- Outputs are registered: seg/an reflect sel and the digit registers one clock after the counter value.
- Reset mid-conversion: state aborts immediately. Digits and last_score return to 0, so a nonzero score restarts a conversion on the first edge after reset deasserts.

Decomposition:
- Package score_display_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - SCORE_W = 14; MAX_BCD = 9999;
  - the 10-entry segment code constant array plus SEG_BLANK and SEG_DASH.
- One natural sub-module: bin_to_bcd_seq, holding the FSM, shift register and busy. It takes start plus a 14-bit value, and outputs four BCD nibbles with a done pulse.
- The refresh counter, blanking and segment decode stay in score_display.

Test Plan:
- Reset, then release with score=0 -> busy never rises. an cycles 1110 with seg=1000000, and 1111 for the three blanked slots.
- score 0 -> 1234 at edge N -> busy high N+1..N+15. From N+15 the digits show an[3..0] slots 1,2,3,4; the an=1110 slot carries seg 0011001 ("4").
- score=16383 -> after 15 cycles all four slots show 0010000 ("9"), i.e. 9999 saturation.
- score=7 -> only an[0] ever goes low, with seg 1111000. Set BLANK_LEADING=0 -> slots 3..1 show 1000000.
- score 100 -> 205 at busy cycle 5 -> the first conversion completes showing 100, a second conversion starts the cycle after DONE, and the display ends at 205.
- Assert reset during SHIFT cycle 7 of converting 4321 -> outputs take reset values in the same cycle. After release, the conversion reruns and shows 4321 at release + 15.
